// File: rtl/alu_pkg.sv
// Shared widths, FSM encoding and the latched-command record for the
// ALU sequencer and its register file.
package alu_pkg;

  localparam int OPW  = 4;  // operand width
  localparam int RESW = 8;  // ALU result width
  localparam int AW   = 2;  // register address width

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [3:0]     s;
    logic           m;
    logic           cn;
    logic [AW-1:0]  rd;
    logic           wb;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } hold_t;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: two async read ports, a load port and a
// write-back port; write-back overrides a load to the same entry.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int RF_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [AW-1:0]  addr_a,
  input  logic [AW-1:0]  addr_b,
  output logic [OPW-1:0] data_a,
  output logic [OPW-1:0] data_b,
  input  logic           ld_en,
  input  logic [AW-1:0]  ld_addr,
  input  logic [OPW-1:0] ld_data,
  input  logic           wb_en,
  input  logic [AW-1:0]  wb_addr,
  input  logic [OPW-1:0] wb_data
);

  logic [OPW-1:0] rf [RF_DEPTH];

  // Addresses beyond a shallow file read as zero and are never written.
  always_comb begin
    data_a = '0;
    data_b = '0;
    if (32'(addr_a) < RF_DEPTH) data_a = rf[addr_a];
    if (32'(addr_b) < RF_DEPTH) data_b = rf[addr_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        if (wb_en && wb_addr == AW'(i))      rf[i] <= wb_data;
        else if (ld_en && ld_addr == AW'(i)) rf[i] <= ld_data;
      end
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one command at a time through an external 4-bit ALU:
// latch operands, run the ALU for a cycle, present the result, write back.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int RF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_s,
  input  logic            cmd_m,
  input  logic            cmd_cn,
  input  logic [AW-1:0]   cmd_ra,
  input  logic [AW-1:0]   cmd_rb,
  input  logic [AW-1:0]   cmd_rd,
  input  logic            cmd_wb,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [OPW-1:0]  ld_data,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [3:0]      alu_s,
  output logic            alu_m,
  output logic            alu_cn,
  input  logic [RESW-1:0] alu_f,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RESW-1:0] res_data,
  output logic            res_zero
);

  logic [1:0]     state;
  hold_t          hold;
  logic [OPW-1:0] rf_a, rf_b;
  logic           wb_en;

  assign wb_en = (state == ST_RESP) && res_valid && res_ready && hold.wb;

  alu_regfile #(.RF_DEPTH(RF_DEPTH)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr_a  (cmd_ra),
    .addr_b  (cmd_rb),
    .data_a  (rf_a),
    .data_b  (rf_b),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .wb_en   (wb_en),
    .wb_addr (hold.rd),
    .wb_data (res_data[OPW-1:0])
  );

  // cmd_ready is registered so it stays low through reset and rises on
  // the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold      <= '0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_valid <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            hold <= '{s: cmd_s, m: cmd_m, cn: cmd_cn, rd: cmd_rd,
                      wb: cmd_wb, a: rf_a, b: rf_b};
            cmd_ready <= 1'b0;
            state     <= ST_EXEC;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          res_data  <= alu_f;
          res_zero  <= (alu_f == '0);
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign alu_a  = hold.a;
  assign alu_b  = hold.b;
  assign alu_s  = hold.s;
  assign alu_m  = hold.m;
  assign alu_cn = hold.cn;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench: vector table, hand-written corner sequences and
// random commands checked against a transaction-level register model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [3:0] cmd_s = '0;
  logic       cmd_m = 1'b0, cmd_cn = 1'b0;
  logic [1:0] cmd_ra = '0, cmd_rb = '0, cmd_rd = '0;
  logic       cmd_wb = 1'b0;
  logic       ld_en = 1'b0;
  logic [1:0] ld_addr = '0;
  logic [3:0] ld_data = '0;
  logic [3:0] alu_a, alu_b, alu_s;
  logic       alu_m, alu_cn;
  logic [7:0] alu_f;
  logic       res_valid, res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_zero;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [3:0] m_rf [4];

  always #5 clk = ~clk;

  alu_seq_ctrl #(.RF_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_s(cmd_s), .cmd_m(cmd_m), .cmd_cn(cmd_cn),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_wb(cmd_wb),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
    .alu_f(alu_f),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero)
  );

  // Stand-in downstream ALU: s=15 concatenates, m=1 XOR, else A+B+!cn.
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] s, input logic m, input logic cn);
    if (s == 4'hF) return {a, b};
    if (m) return {4'h0, a ^ b};
    return {4'h0, a} + {4'h0, b} + {7'h0, ~cn};
  endfunction

  assign alu_f = alu_fn(alu_a, alu_b, alu_s, alu_m, alu_cn);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
    m_rf[a] = d;
  endtask

  // Issues one command from IDLE; optional loads in the acceptance and
  // handshake cycles; holds res_ready low for 'hold' RESP cycles.
  task automatic do_cmd(input logic [3:0] s, input logic m, input logic cn,
                        input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                        input logic wb, input int hold,
                        input logic acc_ld, input logic [1:0] acc_la, input logic [3:0] acc_d,
                        input logic hs_ld, input logic [1:0] hs_la, input logic [3:0] hs_d,
                        output logic [7:0] got);
    logic [3:0] ea, eb;
    logic [7:0] ef;
    int k;
    cmd_s = s; cmd_m = m; cmd_cn = cn; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_wb = wb;
    cmd_valid = 1'b1;
    ld_en = acc_ld; ld_addr = acc_la; ld_data = acc_d;
    ea = m_rf[ra]; eb = m_rf[rb];
    ef = alu_fn(ea, eb, s, m, cn);
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    chk("cmd_ready_idle", 8'(cmd_ready), 8'd1);
    step();
    cmd_valid = 1'b0; ld_en = 1'b0;
    if (acc_ld) m_rf[acc_la] = acc_d;
    res_ready = 1'b1;  // must be ignored while no result is pending
    @(negedge clk);
    chk("exec_alu_a", 8'(alu_a), 8'(ea));
    chk("exec_alu_b", 8'(alu_b), 8'(eb));
    chk("exec_alu_s", 8'(alu_s), 8'(s));
    chk("exec_alu_mcn", {6'd0, alu_m, alu_cn}, {6'd0, m, cn});
    chk("exec_res_valid", 8'(res_valid), 8'd0);
    chk("exec_cmd_ready", 8'(cmd_ready), 8'd0);
    step();
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_ra = ~ra; cmd_s = ~s;  // must be ignored in RESP
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_res_valid", 8'(res_valid), 8'd1);
      chk("hold_res_data", res_data, ef);
      chk("hold_cmd_ready", 8'(cmd_ready), 8'd0);
      chk("hold_alu_a", 8'(alu_a), 8'(ea));
      step();
    end
    res_ready = 1'b1;
    ld_en = hs_ld; ld_addr = hs_la; ld_data = hs_d;
    @(negedge clk);
    chk("resp_res_valid", 8'(res_valid), 8'd1);
    chk("resp_res_data", res_data, ef);
    chk("resp_res_zero", 8'(res_zero), 8'(ef == 8'h0));
    got = res_data;
    step();
    res_ready = 1'b0; ld_en = 1'b0; cmd_valid = 1'b0;
    if (hs_ld) m_rf[hs_la] = hs_d;
    if (wb) m_rf[rd] = ef[3:0];
    @(negedge clk);
    chk("post_res_valid", 8'(res_valid), 8'd0);
    chk("post_cmd_ready", 8'(cmd_ready), 8'd1);
    step();
  endtask

  typedef struct {
    logic [3:0] a, b, s;
    logic       m, cn;
    logic [7:0] f;
    logic       z;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    tbl[0] = '{a: 4'b1010, b: 4'b0110, s: 4'd5,  m: 1'b1, cn: 1'b0, f: 8'b0000_1100, z: 1'b0};
    tbl[1] = '{a: 4'b0111, b: 4'b0101, s: 4'd9,  m: 1'b0, cn: 1'b1, f: 8'b0000_1100, z: 1'b0};
    tbl[2] = '{a: 4'b0011, b: 4'b0011, s: 4'd6,  m: 1'b1, cn: 1'b0, f: 8'h00,        z: 1'b1};
    tbl[3] = '{a: 4'b1111, b: 4'b0001, s: 4'd9,  m: 1'b0, cn: 1'b0, f: 8'h11,        z: 1'b0};
    tbl[4] = '{a: 4'b1100, b: 4'b0101, s: 4'd15, m: 1'b0, cn: 1'b1, f: 8'hC5,        z: 1'b0};
    tbl[5] = '{a: 4'b0000, b: 4'b0000, s: 4'd0,  m: 1'b0, cn: 1'b1, f: 8'h00,        z: 1'b1};
    for (int i = 0; i < 4; i++) m_rf[i] = '0;

    // Reset state
    #2;
    chk("rst_cmd_ready", 8'(cmd_ready), 8'd0);
    chk("rst_res_valid", 8'(res_valid), 8'd0);
    chk("rst_res_data", res_data, 8'h00);
    chk("rst_alu_ab", {alu_a, alu_b}, 8'h00);
    step(); step();
    rst_n = 1'b1;
    step(); step();

    // Vector table: rf0/rf1 operands, result written back to rf2
    for (int i = 0; i < 6; i++) begin
      load(2'd0, tbl[i].a);
      load(2'd1, tbl[i].b);
      do_cmd(tbl[i].s, tbl[i].m, tbl[i].cn, 2'd0, 2'd1, 2'd2, 1'b1, 0,
             1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, got);
      chk("tbl_res_data", got, tbl[i].f);
      chk("tbl_res_zero", 8'(got == 8'h00), 8'(tbl[i].z));
      chk("tbl_wb_rf2", 8'(m_rf[2]), 8'(tbl[i].f[3:0]));
    end
    // Readback of rf2 via a non-writing command
    do_cmd(4'd0, 1'b1, 1'b0, 2'd2, 2'd2, 2'd0, 1'b0, 0,
           1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, got);

    // Long hold in RESP, write-back vs load collision on rf2, load on rf3
    load(2'd0, 4'b1010);
    load(2'd1, 4'b0110);
    do_cmd(4'd5, 1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 5,
           1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 4'b0011, got);
    load(2'd3, 4'b1001);
    do_cmd(4'd5, 1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 0,
           1'b0, 2'd0, 4'd0, 1'b1, 2'd3, 4'b0111, got);
    do_cmd(4'd0, 1'b1, 1'b0, 2'd2, 2'd3, 2'd0, 1'b0, 0,
           1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, got);
    chk("collide_rf2_rf3", got, {4'h0, 4'b1100 ^ 4'b0111});

    // Load to rf0 in the acceptance cycle: operand sees old value
    load(2'd0, 4'b0101);
    load(2'd1, 4'b0101);
    do_cmd(4'd3, 1'b1, 1'b0, 2'd0, 2'd1, 2'd3, 1'b0, 0,
           1'b1, 2'd0, 4'b1111, 1'b0, 2'd0, 4'd0, got);
    chk("acc_ld_old_zero", got, 8'h00);
    do_cmd(4'd3, 1'b1, 1'b0, 2'd0, 2'd0, 2'd3, 1'b0, 0,
           1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, got);

    // Reset during EXEC drops the pending write-back
    load(2'd0, 4'b0101);
    load(2'd1, 4'b0011);
    cmd_s = 4'd9; cmd_m = 1'b0; cmd_cn = 1'b1;
    cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rd = 2'd3; cmd_wb = 1'b1;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_exec_alu_a", 8'(alu_a), 8'h05);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_exec_alu", {alu_a, alu_b}, 8'h00);
    chk("rst_exec_sm", {3'd0, alu_s, alu_m}, 8'h00);
    chk("rst_exec_res", {6'd0, res_valid, res_zero}, 8'h00);
    chk("rst_exec_data", res_data, 8'h00);
    chk("rst_exec_ready", 8'(cmd_ready), 8'd0);
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("rel_cmd_ready", 8'(cmd_ready), 8'd1);
    step();
    do_cmd(4'd0, 1'b1, 1'b0, 2'd3, 2'd0, 2'd1, 1'b0, 0,
           1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, got);
    chk("rst_no_wb_rf3", got, 8'h00);

    // Random commands against the register model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1)
        load(2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)));
      do_cmd(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
             1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
             1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
             1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
             got);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
